melody_sequencer: RTL and testbench

- Plays a fixed note table through the board's tone generator / PWM audio path. The tone path itself is unchanged; this block only schedules it.
- Steps through a ROM of notes (half-period, duration) and hands each half-period to the tone generator over a valid/ready config handshake.
- Gates the tone for the note duration, then inserts a fixed inter-note gap.
- Started and stopped by the audio-enable switch. Sits between the top-level switch/reset inputs and the tone/PWM generator that drives AUD_PWM.

---
 rtl/sound_pkg.sv | 52 +++++
 rtl/tick_divider.sv | 30 +++
 rtl/melody_sequencer.sv | 159 +++++++++++++++
 tb/tb_melody_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and song tables for the board's sound blocks.
// A note is {half_period in clocks, duration in ticks}; a duration of 0 marks the end of the song.
package sound_pkg;

    localparam int NOTE_PERIOD_W = 20;
    localparam int NOTE_DUR_W    = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CHECK = 3'd2,
        ISSUE = 3'd3,
        PLAY  = 3'd4,
        GAP   = 3'd5,
        DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic [NOTE_PERIOD_W-1:0] half_period;
        logic [NOTE_DUR_W-1:0]    dur;
    } note_t;

    // Board melody at 100 MHz, durations in 1 ms ticks.
    localparam int SONG_LEN = 16;
    localparam note_t SONG_ROM [SONG_LEN] = '{
        '{20'd191113, 12'd250}, '{20'd151686, 12'd250}, '{20'd127551, 12'd250},
        '{20'd95557,  12'd500}, '{20'd0,      12'd250}, '{20'd127551, 12'd250},
        '{20'd151686, 12'd250}, '{20'd191113, 12'd500}, '{20'd0,      12'd0},
        '{20'd0,      12'd0},   '{20'd0,      12'd0},   '{20'd0,      12'd0},
        '{20'd0,      12'd0},   '{20'd0,      12'd0},   '{20'd0,      12'd0},
        '{20'd0,      12'd0}
    };

    // Short bring-up song: tone, rest, tone, end marker.
    localparam int TEST_LEN = 4;
    localparam note_t TEST_ROM [TEST_LEN] = '{
        '{20'd50, 12'd3}, '{20'd0, 12'd2}, '{20'd25, 12'd1}, '{20'd0, 12'd0}
    };

    // Entries beyond a table read as the end marker.
    function automatic note_t song_note(input int song_id, input int idx);
        note_t n;
        n = '0;
        if (song_id == 1) begin
            if (idx < TEST_LEN) n = TEST_ROM[idx[1:0]];
        end else if (idx < SONG_LEN) begin
            n = SONG_ROM[idx[3:0]];
        end
        return n;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ/TICK_HZ cycles.
// clr restarts the period so the first tick lands exactly one full period later.
module tick_divider #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic clr,
    input  logic CLK100MHZ,
    input  logic BTNC,
    output logic tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;

    assign tick = (cnt_reg == CNT_W'(DIV - 1));

    always_ff @(posedge CLK100MHZ or posedge BTNC) begin
        if (BTNC) begin
            cnt_reg <= '0;
        end else if (clr || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Walks the song ROM, offers each half-period to the tone generator, then gates
// the tone for the note duration followed by a fixed silent gap.
module melody_sequencer
    import sound_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int NUM_NOTES = 16,
    parameter int PERIOD_W  = 20,
    parameter int DUR_W     = 12,
    parameter int GAP_TICKS = 20,
    parameter bit LOOP      = 1'b1,
    parameter int SONG_ID   = 0
) (
    input  logic                         CLK100MHZ,
    input  logic                         BTNC,
    input  logic                         en,
    output logic                         cfg_valid,
    input  logic                         cfg_ready,
    output logic [PERIOD_W-1:0]          cfg_half_period,
    output logic                         gate,
    output logic [$clog2(NUM_NOTES)-1:0] note_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W = $clog2(NUM_NOTES);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_FETCH = FETCH;
    localparam logic [2:0] S_CHECK = CHECK;
    localparam logic [2:0] S_ISSUE = ISSUE;
    localparam logic [2:0] S_PLAY  = PLAY;
    localparam logic [2:0] S_GAP   = GAP;
    localparam logic [2:0] S_DONE  = DONE;

    logic                en_meta_reg, en_sync_reg;
    logic [2:0]          state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [DUR_W-1:0]    dur_reg, tick_cnt_reg;
    logic [PERIOD_W-1:0] hp_reg;
    logic                gate_reg, valid_reg, done_reg;
    note_t               rom_q;
    logic                tick, clr, rom_end;

    // Registered ROM read: the entry addressed in FETCH is visible in CHECK.
    always_ff @(posedge CLK100MHZ) begin
        rom_q <= song_note(SONG_ID, int'(idx_reg));
    end

    assign rom_end = (rom_q.dur == '0);

    // Every state change restarts the tick period and the tick count.
    assign clr = (state_next != state_reg);

    tick_divider #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .clr      (clr),
        .CLK100MHZ(CLK100MHZ),
        .BTNC     (BTNC),
        .tick     (tick)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE: begin
                idx_next = '0;
                if (en_sync_reg) state_next = S_FETCH;
            end
            S_FETCH: state_next = S_CHECK;
            S_CHECK: begin
                if (rom_end) begin
                    if (LOOP) begin
                        idx_next   = '0;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_DONE;
                    end
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: if (cfg_ready) state_next = S_PLAY;
            S_PLAY: begin
                if (tick && tick_cnt_reg == dur_reg - DUR_W'(1)) begin
                    if (GAP_TICKS == 0) begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (tick && int'(tick_cnt_reg) == GAP_TICKS - 1) begin
                    idx_next   = idx_reg + IDX_W'(1);
                    state_next = S_FETCH;
                end
            end
            S_DONE: state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        // Losing the enable abandons whatever is in flight, including an open handshake.
        if (!en_sync_reg) begin
            state_next = S_IDLE;
            idx_next   = '0;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge BTNC) begin
        if (BTNC) begin
            en_meta_reg  <= 1'b0;
            en_sync_reg  <= 1'b0;
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            tick_cnt_reg <= '0;
            dur_reg      <= '0;
            hp_reg       <= '0;
            valid_reg    <= 1'b0;
            gate_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            en_meta_reg <= en;
            en_sync_reg <= en_meta_reg;
            state_reg   <= state_next;
            idx_reg     <= idx_next;

            if (clr) begin
                tick_cnt_reg <= '0;
            end else if (tick) begin
                tick_cnt_reg <= tick_cnt_reg + DUR_W'(1);
            end

            if (state_reg == S_CHECK && !rom_end) begin
                hp_reg  <= PERIOD_W'(rom_q.half_period);
                dur_reg <= DUR_W'(rom_q.dur);
            end
            if (state_next == S_IDLE || state_next == S_DONE) begin
                hp_reg <= '0;
            end

            valid_reg <= (state_next == S_ISSUE);
            gate_reg  <= (state_next == S_PLAY) && (hp_reg != '0);
            done_reg  <= (state_reg == S_CHECK) && rom_end && !LOOP && en_sync_reg;
        end
    end

    assign cfg_valid       = valid_reg;
    assign cfg_half_period = hp_reg;
    assign gate            = gate_reg;
    assign note_idx        = idx_reg;
    assign done            = done_reg;
    assign busy            = (state_reg != S_IDLE) && (state_reg != S_DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer on the short test song (DIV=10, gap of 2 ticks),
// with one looping instance and one that stops at the end marker.
module tb_melody_sequencer;

    localparam int PW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, en_nl = 1'b0;
    logic cfg_ready = 1'b0, ready_nl = 1'b1;

    logic          cfg_valid, gate, busy, done;
    logic [PW-1:0] cfg_half_period;
    logic [1:0]    note_idx;
    logic          valid_nl, gate_nl, busy_nl, done_nl;
    logic [PW-1:0] hp_nl;
    logic [1:0]    idx_nl;

    always #5 clk = ~clk;

    melody_sequencer #(
        .CLK_HZ(1000), .TICK_HZ(100), .NUM_NOTES(4), .PERIOD_W(PW), .DUR_W(12),
        .GAP_TICKS(2), .LOOP(1'b1), .SONG_ID(1)
    ) dut (
        .CLK100MHZ(clk), .BTNC(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_half_period(cfg_half_period), .gate(gate), .note_idx(note_idx),
        .busy(busy), .done(done)
    );

    melody_sequencer #(
        .CLK_HZ(1000), .TICK_HZ(100), .NUM_NOTES(4), .PERIOD_W(PW), .DUR_W(12),
        .GAP_TICKS(2), .LOOP(1'b0), .SONG_ID(1)
    ) dut_nl (
        .CLK100MHZ(clk), .BTNC(rst), .en(en_nl), .cfg_valid(valid_nl), .cfg_ready(ready_nl),
        .cfg_half_period(hp_nl), .gate(gate_nl), .note_idx(idx_nl),
        .busy(busy_nl), .done(done_nl)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        int idx;
        int hp;
        int hi;
        int hold;
    } exp_t;

    exp_t sb_q[$];
    int   hp_q[$];

    // Advances on negedges until a handshake is visible; leaves time at that negedge.
    task automatic wait_hs(input int max, output int hp, output bit ok);
        ok = 1'b0;
        hp = -1;
        for (int i = 0; i < max && !ok; i++) begin
            if (cfg_valid === 1'b1 && cfg_ready === 1'b1) begin
                ok = 1'b1;
                hp = int'(cfg_half_period);
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic count_gate_high(input int max, output int n);
        n = 0;
        while (gate === 1'b1 && n < max) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_idx_hold(input int idx, input int max, output int n, output bit gate_seen);
        n = 0;
        gate_seen = 1'b0;
        while (int'(note_idx) == idx && n < max) begin
            if (gate !== 1'b0) gate_seen = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int valid_seen, busy_seen;
        rst = 1'b1;
        en = 1'b0;
        cfg_ready = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_valid got=%b exp=0", cfg_valid); end
        n_checks++; if (cfg_half_period !== '0) begin n_fail++; $display("FAIL reset_half_period got=%0d exp=0", cfg_half_period); end
        n_checks++; if (gate !== 1'b0) begin n_fail++; $display("FAIL reset_gate got=%b exp=0", gate); end
        n_checks++; if (note_idx !== 2'd0) begin n_fail++; $display("FAIL reset_note_idx got=%0d exp=0", note_idx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        valid_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            cfg_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (cfg_valid !== 1'b0) valid_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        cfg_ready = 1'b0;
        n_checks++; if (valid_seen != 0) begin n_fail++; $display("FAIL idle_no_valid got=%0d cycles exp=0", valid_seen); end
        n_checks++; if (busy_seen != 0) begin n_fail++; $display("FAIL idle_no_busy got=%0d cycles exp=0", busy_seen); end
        $display("reset: outputs cleared, 100 idle cycles observed");
    endtask

    task automatic test_playback();
        exp_t e;
        int hp, hi, hold, idx_now;
        bit ok, ghi;
        sb_q.push_back('{idx: 0, hp: 50, hi: 30, hold: 20});
        sb_q.push_back('{idx: 1, hp: 0,  hi: 0,  hold: 40});
        sb_q.push_back('{idx: 2, hp: 25, hi: 10, hold: 20});
        sb_q.push_back('{idx: 0, hp: 50, hi: 30, hold: -1});
        cfg_ready = 1'b1;
        en = 1'b1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            wait_hs(60, hp, ok);
            idx_now = int'(note_idx);
            n_checks++; if (!ok || hp != e.hp) begin n_fail++; $display("FAIL play_hp got=%0d exp=%0d", hp, e.hp); end
            n_checks++; if (idx_now != e.idx) begin n_fail++; $display("FAIL play_idx got=%0d exp=%0d", idx_now, e.idx); end
            if (e.hold >= 0) begin
                @(negedge clk);
                count_gate_high(100, hi);
                count_idx_hold(idx_now, 100, hold, ghi);
                n_checks++; if (hi != e.hi) begin n_fail++; $display("FAIL play_gate_cycles got=%0d exp=%0d", hi, e.hi); end
                n_checks++; if (hold != e.hold) begin n_fail++; $display("FAIL play_quiet_cycles got=%0d exp=%0d", hold, e.hold); end
                n_checks++; if (ghi) begin n_fail++; $display("FAIL play_gate_in_quiet got=1 exp=0"); end
            end
            $display("note idx=%0d hp=%0d gate_cycles=%0d quiet_cycles=%0d", idx_now, hp, hi, hold);
        end
    endtask

    task automatic test_en_drop();
        int k, hp;
        bit ok;
        repeat (5) @(negedge clk);
        n_checks++; if (gate !== 1'b1) begin n_fail++; $display("FAIL drop_pre_gate got=%b exp=1", gate); end
        en = 1'b0;
        k = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            @(negedge clk);
            if (gate === 1'b0 && busy === 1'b0 && note_idx === 2'd0 && cfg_valid === 1'b0) k = i;
        end
        n_checks++; if (k == 0 || k > 3) begin n_fail++; $display("FAIL drop_to_idle got=%0d cycles exp<=3", k); end
        en = 1'b1;
        wait_hs(40, hp, ok);
        n_checks++; if (!ok || hp != 50 || note_idx !== 2'd0) begin n_fail++; $display("FAIL drop_restart got hp=%0d idx=%0d exp hp=50 idx=0", hp, note_idx); end
        $display("en drop: idle after %0d cycles, restart hp=%0d", k, hp);
        en = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        int found, bad, hi;
        cfg_ready = 1'b0;
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge clk);
            if (cfg_valid === 1'b1) found = 1;
        end
        n_checks++; if (found == 0) begin n_fail++; $display("FAIL bp_valid_rise got=0 exp=1"); end
        bad = 0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) @(negedge clk);
            if (cfg_valid !== 1'b1 || cfg_half_period !== 20'd50 || gate !== 1'b0 || busy !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold_stable got=%0d bad cycles exp=0", bad); end
        cfg_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (gate !== 1'b1) begin n_fail++; $display("FAIL bp_play_start_gate got=%b exp=1", gate); end
        n_checks++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop got=%b exp=0", cfg_valid); end
        count_gate_high(100, hi);
        n_checks++; if (hi != 30) begin n_fail++; $display("FAIL bp_gate_cycles got=%0d exp=30", hi); end
        $display("backpressure: 7 stalled cycles, gate_cycles=%0d", hi);
    endtask

    task automatic test_btnc();
        int hp;
        bit ok;
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || gate !== 1'b0) begin n_fail++; $display("FAIL btnc_pre_gap got busy=%b gate=%b exp busy=1 gate=0", busy, gate); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL btnc_gap_busy got=%b exp=0", busy); end
        n_checks++; if (cfg_half_period !== '0) begin n_fail++; $display("FAIL btnc_gap_hp got=%0d exp=0", cfg_half_period); end
        n_checks++; if (note_idx !== 2'd0 || cfg_valid !== 1'b0) begin n_fail++; $display("FAIL btnc_gap_idx got idx=%0d valid=%b exp 0", note_idx, cfg_valid); end
        @(negedge clk);
        rst = 1'b0;
        wait_hs(40, hp, ok);
        n_checks++; if (!ok || hp != 50) begin n_fail++; $display("FAIL btnc_restart_hp got=%0d exp=50", hp); end
        repeat (5) @(negedge clk);
        n_checks++; if (gate !== 1'b1) begin n_fail++; $display("FAIL btnc_pre_play_gate got=%b exp=1", gate); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (gate !== 1'b0) begin n_fail++; $display("FAIL btnc_play_gate got=%b exp=0", gate); end
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        $display("btnc: asynchronous clear in gap and in play");
    endtask

    task automatic test_stop();
        int exp_hp, seen_done, extra, stray;
        hp_q.push_back(50);
        hp_q.push_back(0);
        hp_q.push_back(25);
        en_nl = 1'b1;
        seen_done = 0;
        extra = 0;
        for (int i = 0; i < 400 && seen_done == 0; i++) begin
            @(negedge clk);
            if (valid_nl === 1'b1 && ready_nl === 1'b1) begin
                if (hp_q.size() == 0) begin
                    extra++;
                end else begin
                    exp_hp = hp_q.pop_front();
                    n_checks++; if (int'(hp_nl) != exp_hp) begin n_fail++; $display("FAIL stop_hp got=%0d exp=%0d", hp_nl, exp_hp); end
                    $display("stop song: idx=%0d hp=%0d", idx_nl, hp_nl);
                end
            end
            if (done_nl === 1'b1) seen_done = 1;
        end
        n_checks++; if (seen_done == 0) begin n_fail++; $display("FAIL stop_done got=0 exp=1"); end
        n_checks++; if (hp_q.size() != 0 || extra != 0) begin n_fail++; $display("FAIL stop_hs_count got left=%0d extra=%0d exp 0", hp_q.size(), extra); end
        n_checks++; if (busy_nl !== 1'b0) begin n_fail++; $display("FAIL stop_busy got=%b exp=0", busy_nl); end
        @(negedge clk);
        n_checks++; if (done_nl !== 1'b0) begin n_fail++; $display("FAIL stop_done_pulse got=%b exp=0", done_nl); end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_nl !== 1'b0 || valid_nl !== 1'b0 || done_nl !== 1'b0 || gate_nl !== 1'b0) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL stop_done_hold got=%0d active cycles exp=0", stray); end
        en_nl = 1'b0;
        repeat (5) @(negedge clk);
        en_nl = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 30 && seen_done == 0; i++) begin
            @(negedge clk);
            if (valid_nl === 1'b1) seen_done = 1;
        end
        n_checks++; if (seen_done == 0 || hp_nl !== 20'd50 || idx_nl !== 2'd0) begin n_fail++; $display("FAIL stop_replay got valid=%0d hp=%0d idx=%0d exp 1/50/0", seen_done, hp_nl, idx_nl); end
        $display("stop song: done pulse seen, replay hp=%0d", hp_nl);
        en_nl = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_playback();
        test_en_drop();
        test_backpressure();
        test_btnc();
        test_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
